// File: rtl/int_entry_seq.sv
// Interrupt entry / RETI sequencer: saves the PC, fetches the vector byte-wise
// over Wishbone, and redirects the core.
`timescale 1ns/1ps
module int_entry_seq #(
  parameter logic [23:0] SAVE_BASE = 24'h00FF00,
  parameter int          NEST_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic [23:0] ivec_addr,
  input  logic        insn_boundary,
  input  logic [23:0] cur_pc,
  input  logic        reti_req,
  input  logic        ei,
  input  logic        di,
  output logic        core_hold,
  output logic        redirect_valid,
  output logic [23:0] redirect_pc,
  output logic        in_isr,
  output logic        ret_err,
  output logic [23:0] WB_ADRo,
  output logic [7:0]  WB_DATo,
  input  logic [7:0]  WB_DATi,
  output logic        WB_WEo,
  output logic        WB_CYCo,
  output logic        WB_STBo,
  input  logic        WB_ACKi
);

  localparam logic [3:0] NMAX = 4'(NEST_MAX);

  typedef enum logic [3:0] {
    IDLE, SAVE0, SAVE1, SAVE2,
    VEC0, VEC1, VEC2, REDIR,
    RET0, RET1, RET2, RREDIR
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  depth;
  logic        gie;
  logic [23:0] pc_q;
  logic [23:0] vec_q;
  logic [23:0] frame;
  logic        take_ret;
  logic        take_int;
  logic        ret_bad;
  logic        cyc;
  logic        we;
  logic [23:0] adr;
  logic [7:0]  dat;

  assign frame = SAVE_BASE + 24'({depth, 2'b00});

  always_comb begin
    take_ret = 1'b0;
    ret_bad  = 1'b0;
    take_int = 1'b0;
    if (state == IDLE && insn_boundary) begin
      if (reti_req) begin
        take_ret = (depth != 4'd0);
        ret_bad  = (depth == 4'd0);
      end else begin
        take_int = int_req && gie && (depth < NMAX);
      end
    end
  end

  always_comb begin
    state_nx = state;
    cyc      = 1'b0;
    we       = 1'b0;
    adr      = 24'd0;
    dat      = 8'd0;
    unique case (state)
      IDLE: begin
        if (take_ret)      state_nx = RET0;
        else if (take_int) state_nx = SAVE0;
      end
      SAVE0: begin
        cyc = 1'b1;
        we  = 1'b1;
        adr = frame;
        dat = pc_q[7:0];
        if (WB_ACKi) state_nx = SAVE1;
      end
      SAVE1: begin
        cyc = 1'b1;
        we  = 1'b1;
        adr = frame + 24'd1;
        dat = pc_q[15:8];
        if (WB_ACKi) state_nx = SAVE2;
      end
      SAVE2: begin
        cyc = 1'b1;
        we  = 1'b1;
        adr = frame + 24'd2;
        dat = pc_q[23:16];
        if (WB_ACKi) state_nx = VEC0;
      end
      VEC0: begin
        cyc = 1'b1;
        adr = vec_q;
        if (WB_ACKi) state_nx = VEC1;
      end
      VEC1: begin
        cyc = 1'b1;
        adr = vec_q + 24'd1;
        if (WB_ACKi) state_nx = VEC2;
      end
      VEC2: begin
        cyc = 1'b1;
        adr = vec_q + 24'd2;
        if (WB_ACKi) state_nx = REDIR;
      end
      REDIR: state_nx = IDLE;
      // depth is already decremented here, so frame points at the saved PC
      RET0: begin
        cyc = 1'b1;
        adr = frame;
        if (WB_ACKi) state_nx = RET1;
      end
      RET1: begin
        cyc = 1'b1;
        adr = frame + 24'd1;
        if (WB_ACKi) state_nx = RET2;
      end
      RET2: begin
        cyc = 1'b1;
        adr = frame + 24'd2;
        if (WB_ACKi) state_nx = RREDIR;
      end
      RREDIR: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      depth       <= 4'd0;
      gie         <= 1'b0;
      pc_q        <= 24'd0;
      vec_q       <= 24'd0;
      redirect_pc <= 24'd0;
      ret_err     <= 1'b0;
    end else begin
      state   <= state_nx;
      ret_err <= ret_bad;
      if (take_int) begin
        pc_q  <= cur_pc;
        vec_q <= ivec_addr;
      end
      if (take_int)            gie <= 1'b0;
      else if (state == RREDIR) gie <= 1'b1;
      else if (ei && !di)      gie <= 1'b1;
      else if (di && !ei)      gie <= 1'b0;
      if (take_ret)
        depth <= depth - 4'd1;
      else if (state == REDIR && depth < NMAX)
        depth <= depth + 4'd1;
      if (WB_ACKi) begin
        unique case (state)
          VEC0, RET0: redirect_pc[7:0]   <= WB_DATi;
          VEC1, RET1: redirect_pc[15:8]  <= WB_DATi;
          VEC2, RET2: redirect_pc[23:16] <= WB_DATi;
          default: ;
        endcase
      end
    end
  end

  assign core_hold      = (state != IDLE);
  assign redirect_valid = (state == REDIR) || (state == RREDIR);
  assign in_isr         = (depth != 4'd0);
  assign WB_CYCo        = cyc;
  assign WB_STBo        = cyc;
  assign WB_WEo         = we;
  assign WB_ADRo        = adr;
  assign WB_DATo        = dat;

endmodule

// File: tb/tb_int_entry_seq.sv
// Directed bench for int_entry_seq: bus/redirect scoreboard plus
// latency, hold, nesting, priority, wrap and reset checks.
`timescale 1ns/1ps
module tb_int_entry_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int_req = 1'b0;
  logic [23:0] ivec_addr = 24'd0;
  logic        insn_boundary = 1'b0;
  logic [23:0] cur_pc = 24'd0;
  logic        reti_req = 1'b0;
  logic        ei = 1'b0;
  logic        di = 1'b0;
  logic        core_hold;
  logic        redirect_valid;
  logic [23:0] redirect_pc;
  logic        in_isr;
  logic        ret_err;
  logic [23:0] WB_ADRo;
  logic [7:0]  WB_DATo;
  logic [7:0]  WB_DATi = 8'd0;
  logic        WB_WEo;
  logic        WB_CYCo;
  logic        WB_STBo;
  logic        WB_ACKi = 1'b0;

  int_entry_seq dut (
    .clk(clk), .rst(rst), .int_req(int_req), .ivec_addr(ivec_addr),
    .insn_boundary(insn_boundary), .cur_pc(cur_pc), .reti_req(reti_req),
    .ei(ei), .di(di), .core_hold(core_hold),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .in_isr(in_isr), .ret_err(ret_err), .WB_ADRo(WB_ADRo),
    .WB_DATo(WB_DATo), .WB_DATi(WB_DATi), .WB_WEo(WB_WEo),
    .WB_CYCo(WB_CYCo), .WB_STBo(WB_STBo), .WB_ACKi(WB_ACKi)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [23:0] adr;
    logic [7:0]  dat;
  } bus_t;

  bus_t        bus_q[$];
  logic [23:0] red_q[$];
  logic [7:0]  mem [logic [23:0]];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          held = 0;
  logic [23:0] h_adr;
  logic [7:0]  h_dat;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input bit c);
    n_cmp++;
    assert (c) else begin
      n_err++;
      $error("FAIL %s observed=0 expected=1", tag);
    end
  endtask

  // Slave model, bus scoreboard and redirect scoreboard
  always @(negedge clk) begin
    bus_t e;
    logic [23:0] r;
    if (WB_CYCo && WB_STBo) begin
      WB_ACKi = (wait_cnt >= ack_delay);
      WB_DATi = mem.exists(WB_ADRo) ? mem[WB_ADRo] : 8'h00;
    end else begin
      WB_ACKi = 1'b0;
    end
    if (WB_CYCo && WB_STBo && !WB_ACKi) wait_cnt++;
    else wait_cnt = 0;
    if (WB_STBo && held) begin
      chk("stall_adr", 32'(WB_ADRo), 32'(h_adr));
      chk("stall_dat", 32'(WB_DATo), 32'(h_dat));
    end
    held  = WB_STBo && !WB_ACKi;
    h_adr = WB_ADRo;
    h_dat = WB_DATo;
    if (WB_CYCo && WB_STBo && WB_ACKi) begin
      chk_true("bus_expected", bus_q.size() != 0);
      if (bus_q.size() != 0) begin
        e = bus_q.pop_front();
        chk("bus_we", 32'(WB_WEo), 32'(e.we));
        chk("bus_adr", 32'(WB_ADRo), 32'(e.adr));
        if (e.we) chk("bus_dat", 32'(WB_DATo), 32'(e.dat));
      end
      if (WB_WEo) mem[WB_ADRo] = WB_DATo;
    end
    if (redirect_valid) begin
      chk_true("redir_expected", red_q.size() != 0);
      if (red_q.size() != 0) begin
        r = red_q.pop_front();
        chk("redirect_pc", 32'(redirect_pc), 32'(r));
      end
    end
  end

  function automatic logic [23:0] fbase(input int f);
    return 24'h00FF00 + 24'(f * 4);
  endfunction

  task automatic push_save(input logic [23:0] pc, input int f);
    bus_q.push_back({1'b1, fbase(f), pc[7:0]});
    bus_q.push_back({1'b1, fbase(f) + 24'd1, pc[15:8]});
    bus_q.push_back({1'b1, fbase(f) + 24'd2, pc[23:16]});
  endtask

  task automatic push_rd(input logic [23:0] a);
    bus_q.push_back({1'b0, a, 8'h00});
    bus_q.push_back({1'b0, a + 24'd1, 8'h00});
    bus_q.push_back({1'b0, a + 24'd2, 8'h00});
  endtask

  task automatic wait_redirect(input int lat);
    int n;
    bit hold_ok;
    n = 0;
    hold_ok = 1;
    do begin
      @(negedge clk);
      n++;
      if (!core_hold) hold_ok = 0;
    end while (!redirect_valid && n < 200);
    chk("latency", 32'(n), 32'(lat));
    chk_true("hold_throughout", hold_ok);
    @(negedge clk);
  endtask

  task automatic entry(input logic [23:0] pc, input logic [23:0] vec,
                       input int lat, input logic [23:0] exp_pc,
                       input int f);
    push_save(pc, f);
    push_rd(vec);
    red_q.push_back(exp_pc);
    insn_boundary = 1'b1;
    int_req = 1'b1;
    cur_pc = pc;
    ivec_addr = vec;
    @(posedge clk);
    #1;
    insn_boundary = 1'b0;
    int_req = 1'b0;
    cur_pc = 24'd0;
    ivec_addr = 24'd0;
    wait_redirect(lat);
  endtask

  task automatic reti(input logic [23:0] exp_pc, input int f);
    push_rd(fbase(f));
    red_q.push_back(exp_pc);
    insn_boundary = 1'b1;
    reti_req = 1'b1;
    @(posedge clk);
    #1;
    insn_boundary = 1'b0;
    reti_req = 1'b0;
    wait_redirect(4);
  endtask

  task automatic pulse_ei;
    ei = 1'b1;
    @(negedge clk);
    ei = 1'b0;
  endtask

  task automatic no_accept(input string tag);
    int_req = 1'b1;
    insn_boundary = 1'b1;
    ivec_addr = 24'h001010;
    @(posedge clk);
    #1;
    int_req = 1'b0;
    insn_boundary = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_hold"}, 32'(core_hold), 32'd0);
      chk({tag, "_cyc"}, 32'(WB_CYCo), 32'd0);
    end
  endtask

  initial begin
    mem[24'h001010] = 8'h00;
    mem[24'h001011] = 8'h20;
    mem[24'h001012] = 8'h00;
    mem[24'h002000] = 8'h34;
    mem[24'h002001] = 8'h12;
    mem[24'h002002] = 8'h00;
    mem[24'hFFFFFE] = 8'h11;
    mem[24'hFFFFFF] = 8'h22;
    mem[24'h000000] = 8'h33;

    repeat (3) @(negedge clk);
    chk("rst_hold", 32'(core_hold), 32'd0);
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_rpc", 32'(redirect_pc), 32'd0);
    chk("rst_isr", 32'(in_isr), 32'd0);
    chk("rst_reterr", 32'(ret_err), 32'd0);
    chk("rst_cyc", 32'(WB_CYCo), 32'd0);
    chk("rst_stb", 32'(WB_STBo), 32'd0);
    chk("rst_we", 32'(WB_WEo), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    no_accept("gie_off");
    pulse_ei();
    entry(24'h0123AB, 24'h001010, 7, 24'h002000, 0);
    chk("isr_after_entry", 32'(in_isr), 32'd1);
    no_accept("gie_cleared");
    reti(24'h0123AB, 0);
    chk("isr_after_reti", 32'(in_isr), 32'd0);

    ack_delay = 3;
    entry(24'h0ABCDE, 24'h002000, 25, 24'h001234, 0);
    ack_delay = 0;
    reti(24'h0ABCDE, 0);

    for (int i = 0; i < 4; i++) begin
      pulse_ei();
      entry(24'h100000 + 24'(i), 24'h001010, 7, 24'h002000, i);
      chk("nest_isr", 32'(in_isr), 32'd1);
    end
    pulse_ei();
    no_accept("nest_max");
    for (int i = 3; i >= 0; i--) begin
      reti(24'h100000 + 24'(i), i);
      chk("unnest_isr", 32'(in_isr), 32'(i != 0));
    end

    insn_boundary = 1'b1;
    reti_req = 1'b1;
    @(posedge clk);
    #1;
    insn_boundary = 1'b0;
    reti_req = 1'b0;
    @(negedge clk);
    chk("ret_err_pulse", 32'(ret_err), 32'd1);
    chk("ret_err_nocyc", 32'(WB_CYCo), 32'd0);
    chk("ret_err_nohold", 32'(core_hold), 32'd0);
    @(negedge clk);
    chk("ret_err_end", 32'(ret_err), 32'd0);

    entry(24'h000555, 24'h001010, 7, 24'h002000, 0);
    pulse_ei();
    push_rd(fbase(0));
    red_q.push_back(24'h000555);
    insn_boundary = 1'b1;
    int_req = 1'b1;
    reti_req = 1'b1;
    ivec_addr = 24'h001010;
    cur_pc = 24'h000AAA;
    @(posedge clk);
    #1;
    insn_boundary = 1'b0;
    int_req = 1'b0;
    reti_req = 1'b0;
    wait_redirect(4);
    chk("prio_isr", 32'(in_isr), 32'd0);

    entry(24'h000777, 24'hFFFFFE, 7, 24'h332211, 0);
    reti(24'h000777, 0);

    push_save(24'h000999, 0);
    bus_q.push_back({1'b0, 24'hFFFFFE, 8'h00});
    bus_q.push_back({1'b0, 24'hFFFFFF, 8'h00});
    insn_boundary = 1'b1;
    int_req = 1'b1;
    cur_pc = 24'h000999;
    ivec_addr = 24'hFFFFFE;
    @(posedge clk);
    #1;
    insn_boundary = 1'b0;
    int_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("vec1_adr", 32'(WB_ADRo), 32'h00FFFFFF);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cyc", 32'(WB_CYCo), 32'd0);
    chk("mid_rst_stb", 32'(WB_STBo), 32'd0);
    chk("mid_rst_isr", 32'(in_isr), 32'd0);
    chk("mid_rst_rv", 32'(redirect_valid), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("red_q_empty", 32'(red_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
